inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL expose: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL expose: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL expose: in_valid  input  1, in_ready  output  1  request handshake.
REQ-004 SHALL expose: in_type  input  3  immediate type code (RTYPE/ITYPE/STYPE/BTYPE/UTYPE/JTYPE).
REQ-005 SHALL expose: in_imm  input  32  signed byte-offset/immediate value.
REQ-006 SHALL expose: in_opcode 7, in_rd 5, in_rs1 5, in_rs2 5, in_funct3 3, in_funct7 7  inputs  instruction fields.
REQ-007 SHALL expose: out_valid  output  1, out_ready  input  1  result handshake.
REQ-008 SHALL expose: out_instr  output  32  encoded instruction; out_err  output  1  range/type error flag.
REQ-009 SHALL expose: enc_cnt  output  16  instructions emitted; err_cnt  output  8  errors emitted.

Function
REQ-010 Transfer SHALL occur only on a cycle with valid and ready both high, on each port.
REQ-011 Two registered stages: S0 captures the request; S1 holds the encoded result driving out_*.
REQ-012 Latency SHALL be 2 cycles from input accept to out_valid with no backpressure; throughput 1 per cycle.
REQ-013 in_ready SHALL be high when S0 is empty or S0 advances into S1 in the same cycle; a stage advances when the next stage is empty or draining.
REQ-014 out_instr/out_err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-015 Field placement: rd[11:7] for R/I/U/J; rs1[19:15] and funct3[14:12] for R/I/S/B; rs2[24:20] for R/S/B; funct7[31:25] for R; opcode[6:0] always.
REQ-016 ITYPE: imm[11:0] to [31:20]; legal range -2048..2047.
REQ-017 STYPE: imm[11:5] to [31:25], imm[4:0] to [11:7]; range -2048..2047.
REQ-018 BTYPE: imm[12]->31, imm[10:5]->30:25, imm[4:1]->11:8, imm[11]->7; imm even, range -4096..4094.
REQ-019 UTYPE: imm[31:12] to [31:12]; imm[11:0] SHALL be zero.
REQ-020 JTYPE: imm[20]->31, imm[10:1]->30:21, imm[11]->20, imm[19:12]->19:12; imm even, range -1048576..1048574.
REQ-021 RTYPE SHALL ignore in_imm and never raise an error.
REQ-022 Out-of-range, misaligned, or unknown type SHALL give out_err=1 and out_instr=32'h00000013 (NOP).
REQ-023 enc_cnt SHALL increment on each output transfer, saturating at 16'hFFFF.
REQ-024 err_cnt SHALL increment on each output transfer with out_err=1, saturating at 8'hFF.
REQ-025 Simultaneous in-transfer and out-transfer SHALL neither lose nor duplicate an entry.

Reset
REQ-026 rst_n low SHALL asynchronously clear S0/S1 valid, out_valid=0, out_instr=0, out_err=0, enc_cnt=0, err_cnt=0.
REQ-027 in_ready SHALL be 0 while rst_n is low and 1 on the first clock after release.
REQ-028 Reset mid-operation SHALL discard in-flight entries; none SHALL appear after release.

Structure
REQ-029 Type codes SHALL come from the shared parameters header; range limits and NOP constant SHALL be added there.
REQ-030 Field packing and range checking SHALL be one combinational sub-module imm_packer; pipeline/handshake/counters stay in inst_encoder.

Verification
REQ-031 ITYPE opcode 0010011, rd=1, rs1=0, f3=0, imm=5 -> out_instr 32'h00500093, err=0, 2 cycles later.
REQ-032 STYPE opcode 0100011, rs1=0, rs2=2, f3=010, imm=8 -> 32'h00202423; LUI opcode 0110111, rd=5, imm=32'h12345000 -> 32'h123452B7.
REQ-033 BTYPE opcode 1100011, rs1=rs2=0, f3=0, imm=-4 -> 32'hFE000EE3; JTYPE opcode 1101111, rd=1, imm=2048 -> 32'h001000EF.
REQ-034 ITYPE imm=2048, BTYPE imm=3, UTYPE imm=32'h00000001 -> each 32'h00000013, err=1; err_cnt=3.
REQ-035 Back-to-back stream of 8 requests, out_ready toggling 1/0 -> all 8 emitted in order, stable while stalled, enc_cnt=8.
REQ-036 rst_n low with both stages full -> out_valid=0 immediately, counters 0, no stale output after release.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// inst_encoder_pkg: immediate type codes, legal immediate ranges, NOP constant and request layout.
package inst_encoder_pkg;
  typedef enum logic [2:0] {
    RTYPE = 3'd0,
    ITYPE = 3'd1,
    STYPE = 3'd2,
    BTYPE = 3'd3,
    UTYPE = 3'd4,
    JTYPE = 3'd5
  } imm_type_e;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMMB_MIN = -4096;
  localparam int IMMB_MAX = 4094;
  localparam int IMMJ_MIN = -1048576;
  localparam int IMMJ_MAX = 1048574;
  typedef struct packed {
    logic [2:0] typ;
    logic [31:0] imm;
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } req_t;
  function automatic logic in_range(input logic signed [31:0] v, input int lo, input int hi);
    return v >= lo && v <= hi;
  endfunction
endpackage

// File: rtl/inst_encoder_imm_packer.sv
// imm_packer: packs instruction fields by immediate type and flags range, alignment and type errors.
module imm_packer
  import inst_encoder_pkg::*;
(
  input  req_t        req,
  output logic [31:0] instr,
  output logic        err
);
  logic [31:0] i;
  logic [31:0] word;
  logic bad;
  assign i = req.imm;
  always_comb begin
    word = 32'h0;
    bad = 1'b0;
    case (req.typ)
      RTYPE: word = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
      ITYPE: begin
        word = {i[11:0], req.rs1, req.funct3, req.rd, req.opcode};
        bad = !in_range(i, IMM12_MIN, IMM12_MAX);
      end
      STYPE: begin
        word = {i[11:5], req.rs2, req.rs1, req.funct3, i[4:0], req.opcode};
        bad = !in_range(i, IMM12_MIN, IMM12_MAX);
      end
      BTYPE: begin
        word = {i[12], i[10:5], req.rs2, req.rs1, req.funct3, i[4:1], i[11], req.opcode};
        bad = !in_range(i, IMMB_MIN, IMMB_MAX) || i[0];
      end
      UTYPE: begin
        word = {i[31:12], req.rd, req.opcode};
        bad = |i[11:0];
      end
      JTYPE: begin
        word = {i[20], i[10:1], i[11], i[19:12], req.rd, req.opcode};
        bad = !in_range(i, IMMJ_MIN, IMMJ_MAX) || i[0];
      end
      default: bad = 1'b1;
    endcase
  end
  assign instr = bad ? NOP : word;
  assign err = bad;
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: two-stage valid/ready instruction encoder with saturating emit and error counters.
module inst_encoder
  import inst_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_type,
  input  logic [31:0] in_imm,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] enc_cnt,
  output logic [7:0]  err_cnt
);
  req_t s0;
  logic s0_v;
  logic rdy;
  logic s1_free;
  logic [31:0] enc;
  logic enc_err;
  assign s1_free = !out_valid || out_ready;
  // rdy holds in_ready low through reset and rises on the first clock after release
  assign in_ready = rdy && (!s0_v || s1_free);
  imm_packer u_pack (.req(s0), .instr(enc), .err(enc_err));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy <= 1'b0;
      s0_v <= 1'b0;
      s0 <= '0;
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_err <= 1'b0;
      enc_cnt <= 16'h0;
      err_cnt <= 8'h0;
    end else begin
      rdy <= 1'b1;
      if (in_ready) begin
        s0_v <= in_valid;
        s0 <= {in_type, in_imm, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7};
      end
      if (s1_free) begin
        out_valid <= s0_v;
        if (s0_v) begin
          out_instr <= enc;
          out_err <= enc_err;
        end
      end
      if (out_valid && out_ready) begin
        if (!(&enc_cnt)) enc_cnt <= enc_cnt + 16'd1;
        if (out_err && !(&err_cnt)) err_cnt <= err_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed scoreboard bench for inst_encoder.
module tb_inst_encoder;
  import inst_encoder_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [2:0] in_type = 3'd0;
  logic [31:0] in_imm = 32'h0;
  logic [6:0] in_opcode = 7'h0;
  logic [4:0] in_rd = 5'h0;
  logic [4:0] in_rs1 = 5'h0;
  logic [4:0] in_rs2 = 5'h0;
  logic [2:0] in_funct3 = 3'h0;
  logic [6:0] in_funct7 = 7'h0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] out_instr;
  logic out_err;
  logic [15:0] enc_cnt;
  logic [7:0] err_cnt;
  int pass = 0;
  int total = 0;
  int n_sent = 0;
  int n_err = 0;
  logic tog = 1'b0;
  logic stall_v = 1'b0;
  logic [32:0] stall_d;
  logic [32:0] q[$];

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_imm(in_imm), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .enc_cnt(enc_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    total++;
    assert (got === exp) pass++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // scoreboard: every output transfer pops one expectation; held output must match the stalled value
  always @(negedge clk) begin
    if (out_valid) begin
      if (stall_v) chk("stable", {out_err, out_instr}, stall_d);
      if (out_ready) begin
        total++;
        assert (q.size() > 0) pass++;
        else $error("FAIL unexpected_output got=%h exp=none", {out_err, out_instr});
        if (q.size() > 0) chk("out", {out_err, out_instr}, q.pop_front());
      end
      stall_v = !out_ready;
      stall_d = {out_err, out_instr};
    end else stall_v = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (tog) out_ready = !out_ready;
  end

  task automatic send(input logic [2:0] t, input logic [31:0] imm, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [32:0] exp);
    logic r;
    int n;
    in_valid = 1'b1;
    in_type = t; in_imm = imm; in_opcode = op; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7;
    q.push_back(exp);
    n_sent++;
    if (exp[32]) n_err++;
    r = 1'b0;
    n = 0;
    while (!r && n < 100) begin
      @(negedge clk) r = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept", {32'h0, r}, 33'h1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", q.size(), 33'h0);
  endtask

  function automatic logic [32:0] ienc(input int imm, input int rd, input int rs1);
    logic [31:0] v;
    v = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h13;
    return {1'b0, v};
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {32'h0, in_ready}, 33'h0);
    chk("rst_out_valid", {32'h0, out_valid}, 33'h0);
    chk("rst_out", {out_err, out_instr}, 33'h0);
    chk("rst_cnt", {9'h0, enc_cnt, err_cnt}, 33'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", {32'h0, in_ready}, 33'h1);
    out_ready = 1'b1;
    // latency: accepted at this edge, visible two edges after the request was presented
    send(ITYPE, 32'd5, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, {1'b0, 32'h00500093});
    chk("lat_s0", {32'h0, out_valid}, 33'h0);
    @(posedge clk);
    #1;
    chk("lat_s1", {out_valid, out_instr}, {1'b1, 32'h00500093});
    drain();
    send(STYPE, 32'd8, 7'b0100011, 5'd0, 5'd0, 5'd2, 3'b010, 7'd0, {1'b0, 32'h00202423});
    send(UTYPE, 32'h12345000, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, {1'b0, 32'h123452B7});
    send(BTYPE, -32'sd4, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, {1'b0, 32'hFE000EE3});
    send(JTYPE, 32'd2048, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, {1'b0, 32'h001000EF});
    send(ITYPE, 32'd2048, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, {1'b1, NOP});
    send(BTYPE, 32'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, {1'b1, NOP});
    send(UTYPE, 32'h00000001, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, {1'b1, NOP});
    drain();
    chk("err_cnt3", {25'h0, err_cnt}, 33'd3);
    send(ITYPE, -32'sd2048, 7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, {1'b0, 32'h80000013});
    send(JTYPE, 32'd1048574, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, {1'b0, 32'h7FFFF06F});
    send(JTYPE, 32'd1048576, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, {1'b1, NOP});
    send(RTYPE, 32'hDEADBEEF, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, {1'b0, 32'h002081B3});
    send(3'd7, 32'd0, 7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, {1'b1, NOP});
    drain();
    tog = 1'b1;
    for (int k = 0; k < 8; k++)
      send(ITYPE, 32'(k * 3 - 10), 7'b0010011, 5'(k + 1), 5'(k), 5'd0, 3'd0, 7'd0,
           ienc(k * 3 - 10, k + 1, k));
    drain();
    tog = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    chk("enc_cnt", {17'h0, enc_cnt}, 33'(n_sent));
    chk("err_cnt", {25'h0, err_cnt}, 33'(n_err));
    // fill both stages, then reset mid-flight
    out_ready = 1'b0;
    send(ITYPE, 32'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, ienc(1, 1, 0));
    send(ITYPE, 32'd2, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, ienc(2, 2, 0));
    chk("full_out_valid", {32'h0, out_valid}, 33'h1);
    chk("full_in_ready", {32'h0, in_ready}, 33'h0);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_out_valid", {32'h0, out_valid}, 33'h0);
    chk("mid_rst_cnt", {9'h0, enc_cnt, err_cnt}, 33'h0);
    chk("mid_rst_in_ready", {32'h0, in_ready}, 33'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("no_stale", {32'h0, out_valid}, 33'h0);
    end
    chk("post_rst_ready", {32'h0, in_ready}, 33'h1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
